// File: rtl/switch_slot_arbiter.sv
// Slot sequencer/arbiter: clears the shared buffer after reset, then grants
// 3-cycle datapath slots round-robin with per-packet locking.
module switch_slot_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int INIT_DEPTH = 16,
    parameter int AW         = $clog2(INIT_DEPTH)
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic [3:0]           in_cycle_cnt,
    input  logic [NUM_PORTS-1:0] in_req,
    input  logic [NUM_PORTS-1:0] in_req_last,
    output logic [NUM_PORTS-1:0] out_grant,
    output logic                 out_grant_valid,
    output logic                 out_init_we,
    output logic [AW-1:0]        out_init_addr,
    output logic                 out_init_done
);
    localparam int PW = $clog2(NUM_PORTS);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t               state_q;
    logic [PW-1:0]        rr_ptr_q;
    logic                 lock_q;
    logic [NUM_PORTS-1:0] grant_q;
    logic                 grant_valid_q;
    logic                 init_we_q;
    logic [AW-1:0]        init_addr_q;
    logic                 init_done_q;

    logic                 boundary;
    logic                 hold;
    logic                 found;
    logic [PW-1:0]        pick;
    logic [NUM_PORTS-1:0] grant_d;

    assign boundary = (in_cycle_cnt == 4'd2);
    // rr_ptr always names the current owner while a grant is live
    assign hold     = lock_q && in_req[rr_ptr_q] && !in_req_last[rr_ptr_q];

    always_comb begin
        found   = 1'b0;
        pick    = rr_ptr_q;
        grant_d = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            logic [PW-1:0] idx;
            idx = PW'((int'(rr_ptr_q) + i) % NUM_PORTS);
            if (!found && in_req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        if (found) grant_d[pick] = 1'b1;
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q       <= S_INIT;
            rr_ptr_q      <= PW'(NUM_PORTS - 1);
            lock_q        <= 1'b0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            init_we_q     <= 1'b0;
            init_addr_q   <= '0;
            init_done_q   <= 1'b0;
        end else if (state_q == S_INIT) begin
            // first cycle out of reset only raises the strobe at addr 0
            if (!init_we_q) begin
                init_we_q <= 1'b1;
            end else if (init_addr_q == AW'(INIT_DEPTH - 1)) begin
                init_we_q   <= 1'b0;
                init_done_q <= 1'b1;
                state_q     <= S_RUN;
            end else begin
                init_addr_q <= init_addr_q + 1'b1;
            end
        end else if (boundary && !hold) begin
            grant_q       <= grant_d;
            grant_valid_q <= found;
            lock_q        <= found && !in_req_last[pick];
            if (found) rr_ptr_q <= pick;
        end
    end

    assign out_grant       = grant_q;
    assign out_grant_valid = grant_valid_q;
    assign out_init_we     = init_we_q;
    assign out_init_addr   = init_addr_q;
    assign out_init_done   = init_done_q;
endmodule
